pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 108 ++++++++++
 tb/tb_pipe_skid_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-slot pipeline register with skid buffer: registered outputs, in-order delivery,
// exception flush (req) and synchronous reset; in_ready never depends on out_ready.
module pipe_skid_reg #(
    parameter int          DATA_W   = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Power-up values match the reset values so the block is sane before the first reset.
    logic              main_valid_r = 1'b0;
    logic [31:0]       main_pc_r    = RESET_PC;
    logic [31:0]       main_instr_r = 32'h0000_0000;
    logic [DATA_W-1:0] main_data_r  = {DATA_W{1'b0}};
    logic              skid_valid_r = 1'b0;
    logic [31:0]       skid_pc_r    = 32'h0000_0000;
    logic [31:0]       skid_instr_r = 32'h0000_0000;
    logic [DATA_W-1:0] skid_data_r  = {DATA_W{1'b0}};

    logic              accept_s;
    logic              main_load_s;
    logic              skid_load_s;
    logic              main_valid_nxt_s;
    logic [31:0]       main_pc_nxt_s;
    logic [31:0]       main_instr_nxt_s;
    logic [DATA_W-1:0] main_data_nxt_s;

    assign in_ready  = !skid_valid_r && !stall;
    assign out_valid = main_valid_r;
    assign out_pc    = main_pc_r;
    assign out_instr = main_instr_r;
    assign out_data  = main_data_r;
    assign occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

    // Handshake decode and selection of the next main-slot contents.
    always_comb begin
        accept_s         = in_valid && in_ready;
        main_load_s      = !main_valid_r || out_ready;
        skid_load_s      = accept_s && main_valid_r && !out_ready;
        main_valid_nxt_s = 1'b0;
        main_pc_nxt_s    = RESET_PC;
        main_instr_nxt_s = 32'h0000_0000;
        main_data_nxt_s  = {DATA_W{1'b0}};
        if (skid_valid_r) begin
            main_valid_nxt_s = 1'b1;
            main_pc_nxt_s    = skid_pc_r;
            main_instr_nxt_s = skid_instr_r;
            main_data_nxt_s  = skid_data_r;
        end else if (accept_s) begin
            main_valid_nxt_s = 1'b1;
            main_pc_nxt_s    = in_pc;
            main_instr_nxt_s = in_instr;
            main_data_nxt_s  = in_data;
        end else begin
            main_valid_nxt_s = 1'b0;
            main_pc_nxt_s    = RESET_PC;
        end
    end

    // Slot registers: reset beats flush, flush beats normal traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_pc_r    <= RESET_PC;
            main_instr_r <= 32'h0000_0000;
            main_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
        end else if (req) begin
            main_valid_r <= 1'b0;
            main_pc_r    <= EXC_PC;
            main_instr_r <= 32'h0000_0000;
            main_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
        end else begin
            if (main_load_s) begin
                main_valid_r <= main_valid_nxt_s;
                main_pc_r    <= main_pc_nxt_s;
                main_instr_r <= main_instr_nxt_s;
                main_data_r  <= main_data_nxt_s;
            end
            // Skid only fills while it is empty, so fill and drain never coincide.
            if (skid_load_s) begin
                skid_valid_r <= 1'b1;
                skid_pc_r    <= in_pc;
                skid_instr_r <= in_instr;
                skid_data_r  <= in_data;
            end else if (main_load_s && skid_valid_r) begin
                skid_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a random stream,
// compared against a queue-based model of held entries.
module tb_pipe_skid_reg;
    localparam int          DW       = 128;
    localparam logic [31:0] RST_PC   = 32'h0000_3000;
    localparam logic [31:0] EXCP_PC  = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset, req, stall, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_pc, in_instr, out_pc, out_instr;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t q[$];
    logic [31:0] bubble_pc = RST_PC;

    pipe_skid_reg #(.DATA_W(DW), .RESET_PC(RST_PC), .EXC_PC(EXCP_PC)) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        if (q.size() > 0) begin
            chk({tag, ".valid"}, DW'(out_valid), DW'(1'b1));
            chk({tag, ".pc"}, DW'(out_pc), DW'(q[0].pc));
            chk({tag, ".instr"}, DW'(out_instr), DW'(q[0].instr));
            chk({tag, ".data"}, out_data, q[0].data);
        end else begin
            chk({tag, ".valid"}, DW'(out_valid), DW'(1'b0));
            chk({tag, ".pc"}, DW'(out_pc), DW'(bubble_pc));
            chk({tag, ".instr"}, DW'(out_instr), DW'(32'h0));
            chk({tag, ".data"}, out_data, {DW{1'b0}});
        end
        chk({tag, ".occ"}, DW'(occupancy), DW'(q.size()));
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [DW-1:0] data,
                        input logic ordy, input logic stl, input logic rq, input logic rst);
        logic rdy, drain;
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_pc = pc; in_instr = instr; in_data = data;
        out_ready = ordy; stall = stl; req = rq; reset = rst;
        #1;
        rdy = (q.size() < 2) && !stl;
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(rdy));
        @(posedge clk);
        if (rst) begin
            q.delete(); bubble_pc = RST_PC;
        end else if (rq) begin
            q.delete(); bubble_pc = EXCP_PC;
        end else begin
            drain = (q.size() > 0) && ordy;
            if (drain) void'(q.pop_front());
            if (iv && rdy) begin
                e.pc = pc; e.instr = instr; e.data = data;
                q.push_back(e);
            end
            bubble_pc = RST_PC;
        end
        #1;
        chk_out(tag);
    endtask

    task automatic do_reset();
        step("reset", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int acc;
        logic iv, ordy, stl;
        logic [31:0] pc;
        reset = 1'b0; req = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'h0; in_instr = 32'h0; in_data = {DW{1'b0}};
        #1;
        chk_out("preset");
        do_reset();

        // Single entry, one-cycle latency
        step("lat", 1'b1, 32'h3000, 32'h2401_0001, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lat_drain", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill both slots, then drain in order
        do_reset();
        step("fill0", 1'b1, 32'h3000, 32'h1111_0000, {4{32'hA5A5_0001}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fill1", 1'b1, 32'h3004, 32'h1111_0004, {4{32'hA5A5_0002}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("full", 1'b1, 32'h3008, 32'h1111_0008, {4{32'hA5A5_0003}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drain0", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
        step("drain1", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);
        step("empty", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush while full, with in_valid discarded
        step("f_fill0", 1'b1, 32'h3000, 32'h2, {DW{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("f_fill1", 1'b1, 32'h3004, 32'h3, {DW{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h300C, 32'h4, {DW{1'b1}}, 1'b0, 1'b1, 1'b1, 1'b0);
        step("post_flush", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall blocks acceptance but not draining
        step("s_load", 1'b1, 32'h3008, 32'h5, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("s_stall", 1'b1, 32'h300C, 32'h6, {DW{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s_stall2", 1'b1, 32'h300C, 32'h6, {DW{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s_release", 1'b1, 32'h300C, 32'h6, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous accept and drain keeps occupancy at 1
        step("swap", 1'b1, 32'h3010, 32'h7, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset beats flush while full
        step("r_fill", 1'b1, 32'h3014, 32'h8, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r_both", 1'b1, 32'h3018, 32'h9, {DW{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1);

        // Random stream of 100 entries
        acc = 0;
        pc  = 32'h0001_0000;
        for (int c = 0; c < 3000 && acc < 100; c++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 3) != 0);
            stl  = 1'($urandom_range(0, 4) == 0);
            if (iv && (q.size() < 2) && !stl) acc++;
            step("rand", iv, pc, $urandom, {$urandom, $urandom, $urandom, $urandom},
                 ordy, stl, 1'b0, 1'b0);
            if (out_valid === 1'b1 || iv) pc = pc + 32'h4;
        end
        chk("rand_count", DW'(acc), DW'(100));
        for (int c = 0; c < 4; c++)
            step("rand_drain", 1'b0, 32'h0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
